// File: rtl/prt_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prt_dp_pkg
// Brief    : Shared DP TX constants and 8b/10b sub-block table helpers.
// Revision : 1.0 - initial release
// ============================================================================
package prt_dp_pkg;

    localparam logic       c_RD_NEG     = 1'b0;
    localparam logic       c_RD_POS     = 1'b1;
    localparam logic [9:0] c_K28_5_NEG  = 10'h17C;
    localparam logic [9:0] c_K28_5_POS  = 10'h283;

    localparam int c_SYM_W    = 11;
    localparam int c_CODE_W   = 10;
    localparam int c_DISP_CTL = 10;
    localparam int c_DISP_VAL = 9;
    localparam int c_K        = 8;
    localparam int c_DAT_MSB  = 7;
    localparam int c_DAT_LSB  = 0;

    // 5b/6b data code at RD-, written abcdei with a in the MSB
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        logic [5:0] r;
        case (x)
            5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
            5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
            5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
            5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
            5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
            5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
            5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
            5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
            5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
            5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
            5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
            5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
            5'd30: r = 6'b011110;  default: r = 6'b101011;
        endcase
        return r;
    endfunction

    // 3b/4b data code for RD- after the 6b block, fghj with f in the MSB
    function automatic logic [3:0] enc4_neg(input logic [2:0] y, input logic alt7);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;  3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;  default: r = alt7 ? 4'b0111 : 4'b1110;
        endcase
        return r;
    endfunction

    // Control 3b/4b code for RD- after the 6b block; RD+ is always its complement
    function automatic logic [3:0] enc4k_neg(input logic [2:0] y);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;  3'd1: r = 4'b0110;
            3'd2: r = 4'b1010;  3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;  3'd5: r = 4'b0101;
            3'd6: r = 4'b1001;  default: r = 4'b0111;
        endcase
        return r;
    endfunction

    function automatic logic k_supported(input logic [7:0] dat);
        logic [4:0] x;
        x = dat[4:0];
        return (x == 5'd28) ||
               ((dat[7:5] == 3'd7) &&
                ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/prt_dptx_enc_sym.sv
`default_nettype none
// ============================================================================
// Module   : prt_dptx_enc_sym
// Brief    : Combinational single-symbol 8b/10b encoder with RD in/out.
// Revision : 1.0 - initial release
// ============================================================================
module prt_dptx_enc_sym
    import prt_dp_pkg::*;
(
    input  logic [7:0] i_dat,
    input  logic       i_k,
    input  logic       i_rd,
    output logic [9:0] o_code,
    output logic       o_rd,
    output logic       o_kerr
);

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_6n, w_6;
    logic [3:0] w_4n, w_4;
    logic       w_flip6, w_cmp6, w_rd6, w_alt7, w_flip4, w_cmp4;

    always_comb begin
        w_x     = i_dat[4:0];
        w_y     = i_dat[7:5];
        o_kerr  = i_k && !k_supported(i_dat);

        w_6n    = (i_k && (w_x == 5'd28)) ? 6'b001111 : enc6_neg(w_x);
        w_flip6 = ($countones(w_6n) != 3);
        // D.07 is balanced yet still has distinct RD+/RD- forms
        w_cmp6  = w_flip6 || (!i_k && (w_x == 5'd7));
        w_6     = (i_rd && w_cmp6) ? ~w_6n : w_6n;
        w_rd6   = i_rd ^ w_flip6;

        w_alt7  = w_rd6 ? ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))
                        : ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20));
        w_4n    = i_k ? enc4k_neg(w_y) : enc4_neg(w_y, w_alt7);
        w_flip4 = ($countones(w_4n) != 2);
        w_cmp4  = w_flip4 || i_k || (w_y == 3'd3);
        w_4     = (w_rd6 && w_cmp4) ? ~w_4n : w_4n;

        if (o_kerr) begin
            o_code = (i_rd == c_RD_POS) ? c_K28_5_POS : c_K28_5_NEG;
            o_rd   = ~i_rd;
        end else begin
            o_code = {w_4[0], w_4[1], w_4[2], w_4[3],
                      w_6[0], w_6[1], w_6[2], w_6[3], w_6[4], w_6[5]};
            o_rd   = w_rd6 ^ w_flip4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prt_dptx_enc.sv
`default_nettype none
// ============================================================================
// Module   : prt_dptx_enc
// Brief    : Multi-lane 8b/10b encoder, two-stage pipeline, per-lane RD chain.
// Revision : 1.0 - initial release
// ============================================================================
module prt_dptx_enc
    import prt_dp_pkg::*;
#(
    parameter int P_LANES = 4,
    parameter int P_SPL   = 2
) (
    input  logic                           LNK_CLK_IN,
    input  logic                           LNK_RST_IN,
    input  logic                           LNK_VLD_IN,
    input  logic [P_LANES*P_SPL*11-1:0]    LNK_DAT_IN,
    output logic                           LNK_VLD_OUT,
    output logic [P_LANES*P_SPL*10-1:0]    LNK_DAT_OUT,
    output logic [P_LANES-1:0]             STA_KERR_OUT
);

    localparam int c_IW = P_LANES * P_SPL * c_SYM_W;
    localparam int c_OW = P_LANES * P_SPL * c_CODE_W;

    logic               r_vld1;
    logic [c_IW-1:0]    r_dat1;
    logic               r_vld2;
    logic [c_OW-1:0]    r_code;
    logic [P_LANES-1:0] r_kerr;
    logic [P_LANES-1:0] r_rd;

    logic [c_OW-1:0]    w_code;
    logic [P_LANES-1:0] w_kerr;
    logic [P_LANES-1:0] w_rd_next;

    generate
        for (genvar i = 0; i < P_LANES; i++) begin : g_lane
            logic [P_SPL-1:0] w_kerr_slot;
            for (genvar j = 0; j < P_SPL; j++) begin : g_slot
                localparam int c_IO = (i * P_SPL + j) * c_SYM_W;
                localparam int c_OO = (i * P_SPL + j) * c_CODE_W;
                logic [c_SYM_W-1:0] w_sym;
                logic               w_rd_prev;
                logic               w_rd_in;
                logic               w_rd_out;

                if (j == 0) begin : g_first
                    assign w_rd_prev = r_rd[i];
                end else begin : g_chain
                    assign w_rd_prev = g_slot[j-1].w_rd_out;
                end

                assign w_sym   = r_dat1[c_IO +: c_SYM_W];
                // A forced disparity overrides whatever the previous slot produced
                assign w_rd_in = w_sym[c_DISP_CTL] ? w_sym[c_DISP_VAL] : w_rd_prev;

                prt_dptx_enc_sym u_sym (
                    .i_dat  (w_sym[c_DAT_MSB:c_DAT_LSB]),
                    .i_k    (w_sym[c_K]),
                    .i_rd   (w_rd_in),
                    .o_code (w_code[c_OO +: c_CODE_W]),
                    .o_rd   (w_rd_out),
                    .o_kerr (w_kerr_slot[j])
                );
            end
            assign w_kerr[i]    = |w_kerr_slot;
            assign w_rd_next[i] = g_slot[P_SPL-1].w_rd_out;
        end
    endgenerate

    always_ff @(posedge LNK_CLK_IN) begin
        if (LNK_RST_IN) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
            r_vld2 <= 1'b0;
            r_code <= '0;
            r_kerr <= '0;
            r_rd   <= {P_LANES{c_RD_NEG}};
        end else begin
            r_vld1 <= LNK_VLD_IN;
            r_dat1 <= LNK_DAT_IN;
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_code <= w_code;
                r_kerr <= w_kerr;
                r_rd   <= w_rd_next;
            end else begin
                r_kerr <= '0;
            end
        end
    end

    assign LNK_VLD_OUT  = r_vld2;
    assign LNK_DAT_OUT  = r_code;
    assign STA_KERR_OUT = r_kerr;

endmodule
`default_nettype wire

// File: tb/tb_prt_dptx_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_prt_dptx_enc
// Brief    : Directed vector bench for the multi-lane 8b/10b encoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prt_dptx_enc;

    localparam int c_LANES = 4;
    localparam int c_SPL   = 2;
    localparam int c_IW    = c_LANES * c_SPL * 11;
    localparam int c_OW    = c_LANES * c_SPL * 10;
    localparam int c_NV    = 25;

    localparam logic [10:0] c_K285    = {2'b00, 1'b1, 8'hBC};
    localparam logic [10:0] c_K285_FP = {2'b11, 1'b1, 8'hBC};
    localparam logic [10:0] c_KBAD    = {2'b00, 1'b1, 8'h00};
    localparam logic [10:0] c_K287    = {2'b00, 1'b1, 8'hFC};
    localparam logic [10:0] c_K237    = {2'b00, 1'b1, 8'hF7};
    localparam logic [10:0] c_D00     = {2'b00, 1'b0, 8'h00};
    localparam logic [10:0] c_D00_FP  = {2'b11, 1'b0, 8'h00};
    localparam logic [10:0] c_D215    = {2'b00, 1'b0, 8'hB5};
    localparam logic [10:0] c_D117    = {2'b00, 1'b0, 8'hEB};
    localparam logic [10:0] c_D177    = {2'b00, 1'b0, 8'hF1};

    typedef struct {
        logic               vld;
        logic [c_IW-1:0]    din;
        logic [c_OW-1:0]    dout;
        logic [c_LANES-1:0] kerr;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vld_in = 1'b0;
    logic [c_IW-1:0]    din = '0;
    logic               vld_out;
    logic [c_OW-1:0]    dout;
    logic [c_LANES-1:0] kerr;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[c_NV];

    always #5 clk = ~clk;

    prt_dptx_enc #(.P_LANES(c_LANES), .P_SPL(c_SPL)) u_dut (
        .LNK_CLK_IN   (clk),
        .LNK_RST_IN   (rst),
        .LNK_VLD_IN   (vld_in),
        .LNK_DAT_IN   (din),
        .LNK_VLD_OUT  (vld_out),
        .LNK_DAT_OUT  (dout),
        .STA_KERR_OUT (kerr)
    );

    function automatic logic [c_IW-1:0] din2(input logic [10:0] s0, input logic [10:0] s1);
        return {c_LANES{s1, s0}};
    endfunction

    function automatic logic [c_OW-1:0] dout2(input logic [9:0] c0, input logic [9:0] c1);
        return {c_LANES{c1, c0}};
    endfunction

    function automatic logic [c_IW-1:0] din8(input logic [10:0] a0, a1, b0, b1, c0, c1, d0, d1);
        return {d1, d0, c1, c0, b1, b0, a1, a0};
    endfunction

    function automatic logic [c_OW-1:0] dout8(input logic [9:0] a0, a1, b0, b1, c0, c1, d0, d1);
        return {d1, d0, c1, c0, b1, b0, a1, a0};
    endfunction

    task automatic check(input string name, input logic [c_OW-1:0] act, input logic [c_OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic v, input logic [c_IW-1:0] d,
                        input logic [c_OW-1:0] q, input logic [c_LANES-1:0] ke);
        vecs[i].vld  = v;
        vecs[i].din  = d;
        vecs[i].dout = q;
        vecs[i].kerr = ke;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen;

        // Running disparity noted after each word (all lanes unless stated)
        setv(0,  1, din2(c_K285, c_K285),       dout2(10'h17C, 10'h283), 4'b0000); // -
        setv(1,  1, din2(c_K285, c_K285),       dout2(10'h17C, 10'h283), 4'b0000); // -
        setv(2,  1, din2(c_D00, c_D00),         dout2(10'h0B9, 10'h0B9), 4'b0000); // -
        setv(3,  1, din2(c_D215, c_D215),       dout2(10'h155, 10'h155), 4'b0000); // -
        setv(4,  1, din2(c_K285_FP, c_K285),    dout2(10'h283, 10'h17C), 4'b0000); // +
        setv(5,  1, din8(c_K285, c_K285, c_K285, c_K285, c_KBAD, c_K285, c_K285, c_K285),
                    dout2(10'h283, 10'h17C), 4'b0100);                             // +
        setv(6,  1, din2(c_K285, c_K285),       dout2(10'h283, 10'h17C), 4'b0000); // +
        setv(7,  1, din2(c_K285_FP, c_K285),    dout2(10'h283, 10'h17C), 4'b0000); // +
        setv(8,  1, din2(c_K285, c_K285_FP),    dout2(10'h283, 10'h283), 4'b0000); // -
        setv(9,  1, din2(c_K285, c_K285),       dout2(10'h17C, 10'h283), 4'b0000); // -
        setv(10, 1, din2(c_D117, c_D117),       dout2(10'h1CB, 10'h04B), 4'b0000); // -
        setv(11, 1, din2(c_D177, c_D177),       dout2(10'h3B1, 10'h231), 4'b0000); // -
        setv(12, 1, din2(c_K287, c_K287),       dout2(10'h07C, 10'h07C), 4'b0000); // -
        setv(13, 1, din2(c_K237, c_K237),       dout2(10'h057, 10'h057), 4'b0000); // -
        setv(14, 1, din2(c_D00_FP, c_D00),      dout2(10'h346, 10'h346), 4'b0000); // +
        setv(15, 1, din8(c_D215, c_D00, c_D00, c_D215, c_K285, c_K285, c_D117, c_D117),
                    dout8(10'h155, 10'h346, 10'h346, 10'h155,
                          10'h283, 10'h17C, 10'h04B, 10'h1CB), 4'b0000);           // +
        setv(16, 1, din2(c_K287, c_K287),       dout2(10'h383, 10'h383), 4'b0000); // +
        setv(17, 1, din2(c_K237, c_K237),       dout2(10'h3A8, 10'h3A8), 4'b0000); // +
        setv(18, 1, din2(c_K285, c_K285),       dout2(10'h283, 10'h17C), 4'b0000); // +
        for (int i = 19; i < 24; i++)
            setv(i, 0, din2(c_K285, c_D00),     dout2(10'h283, 10'h17C), 4'b0000); // held
        setv(24, 1, din2(c_K285, c_K285),       dout2(10'h283, 10'h17C), 4'b0000); // +

        // Reset with live input: outputs must stay at reset values
        rst    = 1'b1;
        vld_in = 1'b1;
        din    = din2(c_K285, c_K285);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dat", dout, '0);
        check("reset_ctl", {vld_out, kerr}, '0);
        rst    = 1'b0;
        vld_in = 1'b0;

        for (int c = 0; c <= c_NV; c++) begin
            if (c < c_NV) begin
                vld_in = vecs[c].vld;
                din    = vecs[c].din;
            end else begin
                vld_in = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c >= 1) begin
                check($sformatf("vec%0d_dat", c - 1), dout, vecs[c-1].dout);
                check($sformatf("vec%0d_vld_kerr", c - 1), {vld_out, kerr},
                      {vecs[c-1].vld, vecs[c-1].kerr});
            end
        end

        // Mid-stream reset while every lane sits at RD+
        vld_in = 1'b1;
        din    = din2(c_K285, c_K285);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_dat", dout, dout2(10'h283, 10'h17C));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dat", dout, '0);
        check("midrst_ctl", {vld_out, kerr}, '0);
        rst  = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (vld_out) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check("midrst_latency", lat, 2);
        check("midrst_first_dat", dout, dout2(10'h17C, 10'h283));
        vld_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
